// File: rtl/nibble_serial_negate_ctrl_pkg.sv
// Shared state encoding and datapath width for the nibble-serial negator.
`timescale 1ns/1ps
package nibble_serial_negate_ctrl_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_negate_ctrl_nibble_neg_inc.sv
// 4-bit invert-and-increment slice: {cout, s} = ~nib + cin.
`timescale 1ns/1ps
module nibble_neg_inc (
  input  logic [3:0] nib,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  assign {cout, s} = {1'b0, ~nib} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_negate_ctrl.sv
// Two's-complement negator reusing one 4-bit slice, LSB nibble first, carry rippled per cycle.
// Optional NEG_OVF_DETECT_EN adds out_ovf, flagging the unrepresentable most-negative operand.
`timescale 1ns/1ps
module nibble_serial_negate_ctrl
  import nibble_serial_negate_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_neg,
  output logic             out_zero,
  output logic             busy
`ifdef NEG_OVF_DETECT_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int unsigned NIBBLES = WIDTH / NIB_W;
  localparam int unsigned IdxW    = $clog2(NIBBLES);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [NIB_W-1:0] nib_in, nib_s;
  logic             nib_cout;

  assign nib_in = opnd_q[idx_q*NIB_W +: NIB_W];

  nibble_neg_inc u_nib (
    .nib  (nib_in),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_cout)
  );

`ifdef NEG_OVF_DETECT_EN
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    opnd_d   = opnd_q;
    result_d = result_q;
`ifdef NEG_OVF_DETECT_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          opnd_d   = in_a;
          carry_d  = 1'b1;
          idx_d    = '0;
          result_d = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        result_d[idx_q*NIB_W +: NIB_W] = nib_s;
        carry_d = nib_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StDone;
`ifdef NEG_OVF_DETECT_EN
          ovf_d   = (opnd_q == MinVal);
`endif
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
`ifdef NEG_OVF_DETECT_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      opnd_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
    end
  end

`ifdef NEG_OVF_DETECT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end
  assign out_ovf = ovf_q;
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign out_neg   = result_q;
  // Carry register holds intermediate values during RUN; expose it only once final.
  assign out_zero  = out_valid & carry_q;

endmodule

// File: tb/tb_nibble_serial_negate_ctrl.sv
// Scoreboard bench: randomized and directed operands, reference negation from plain arithmetic.
`timescale 1ns/1ps
module tb_nibble_serial_negate_ctrl;

  localparam int unsigned W  = 16;
  localparam int unsigned W8 = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, out_zero, busy;
  logic [W-1:0]  in_a, out_neg;
  logic          in_valid8, in_ready8, out_valid8, out_zero8, busy8;
  logic          out_ready8;
  logic [W8-1:0] in_a8, out_neg8;
`ifdef NEG_OVF_DETECT_EN
  logic          out_ovf, out_ovf8;
`endif

  always #5 clk = ~clk;

  nibble_serial_negate_ctrl #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_neg   (out_neg),
    .out_zero  (out_zero),
    .busy      (busy)
`ifdef NEG_OVF_DETECT_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  nibble_serial_negate_ctrl #(.WIDTH(W8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .in_a      (in_a8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_neg   (out_neg8),
    .out_zero  (out_zero8),
    .busy      (busy8)
`ifdef NEG_OVF_DETECT_EN
    ,
    .out_ovf   (out_ovf8)
`endif
  );

  typedef struct packed {
    logic [W-1:0] neg;
    logic         zero;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   bp_random = 1'b0;

  function automatic exp_t model(input logic [W-1:0] a);
    exp_t e;
    e.neg  = W'((longint'(1) << W) - longint'(a));
    e.zero = (a == '0);
    e.ovf  = ($signed(a) == -(longint'(1) << (W - 1)));
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired, expected event did not occur (t=%0t)", name, $time);
  endtask

  // Monitor: compare every presented result against the queue head; pop on handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got out_neg %0h, expected no result", out_neg);
      end else begin
        check("out_neg", 32'(out_neg), 32'(sb_q[0].neg));
        check("out_zero", 32'(out_zero), 32'(sb_q[0].zero));
`ifdef NEG_OVF_DETECT_EN
        check("out_ovf", 32'(out_ovf), 32'(sb_q[0].ovf));
`endif
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  always begin
    @(posedge clk);
    #2;
    if (bp_random) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [W-1:0] a);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      fail_now("accept_timeout");
      return;
    end
    in_valid = 1'b1;
    in_a     = a;
    sb_q.push_back(model(a));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = W'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) begin
      fail_now("drain_timeout");
      sb_q.delete();
    end
  endtask

  task automatic op8(input logic [W8-1:0] a, input logic [W8-1:0] exp_neg, input logic exp_zero);
    int guard = 0;
    @(negedge clk);
    in_valid8 = 1'b1;
    in_a8     = a;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    @(negedge clk);
    while (!out_valid8 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid8) fail_now("w8_valid_timeout");
    else begin
      check("w8_out_neg", 32'(out_neg8), 32'(exp_neg));
      check("w8_out_zero", 32'(out_zero8), 32'(exp_zero));
    end
  endtask

  initial begin
    int k;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_a       = '0;
    out_ready  = 1'b1;
    in_valid8  = 1'b0;
    in_a8      = '0;
    out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_neg", 32'(out_neg), 32'd0);
    check("rst_out_zero", 32'(out_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic op with latency measurement
    send(16'h0001);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 20);
    check("latency", 32'(k - 1), 32'd4);
    drain();

    send(16'h0000);
    send(16'h0100);
    send(16'h1234);
    drain();

    // Backpressure: result must hold and a new operand must be refused
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    send(16'h00F0);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) fail_now("bp_valid_timeout");
    in_valid = 1'b1;
    in_a     = 16'h0005;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    drain();
    repeat (2) @(negedge clk);
    check("bp_not_accepted", 32'(busy), 32'd0);

    // Asynchronous reset mid-RUN
    send(16'h7777);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_neg", 32'(out_neg), 32'd0);
    check("mid_rst_out_zero", 32'(out_zero), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h0003);
    drain();

    send(16'h8000);
    send(16'h7FFF);
    drain();

    bp_random = 1'b1;
    for (int i = 0; i < 40; i++) send(W'($urandom));
    drain();
    bp_random = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;

    // Smoke run at WIDTH=8
    op8(8'h01, 8'hFF, 1'b0);
    op8(8'h00, 8'h00, 1'b1);
    op8(8'h80, 8'h80, 1'b0);
    op8(8'h3C, 8'hC4, 1'b0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
